// File: rtl/snn_mem_pkg.sv
// Shared sizing and FSM encoding for the spike-word SRAM responder.
package snn_mem_pkg;

    localparam int SPK_AW    = 9;
    localparam int SPK_DW    = 16;
    localparam int SPK_DEPTH = 512;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } spk_state_e;

endpackage

// File: rtl/spk_sram_array.sv
// Single-write, dual-read spike SRAM with registered reads and write-first bypass.
module spk_sram_array
    import snn_mem_pkg::*;
#(
    parameter int AW    = SPK_AW,
    parameter int DW    = SPK_DW,
    parameter int DEPTH = SPK_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en_a,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic          rd_en_b,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    // Storage is never reset; only the clear sweep in the top initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (rd_en_a) begin
                rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
            end
            if (rd_en_b) begin
                rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/spk_sram_responder.sv
// Spike SRAM front end: power-up clear sweep, then accelerator port with priority
// over a valid/ready host port sharing the single write port.
module spk_sram_responder
    import snn_mem_pkg::*;
#(
    parameter int AW    = SPK_AW,
    parameter int DW    = SPK_DW,
    parameter int DEPTH = SPK_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] spk_read_sram_addr,
    output logic [DW-1:0] spk_read_sram,
    input  logic [AW-1:0] spk_write_sram_addr,
    input  logic [DW-1:0] spk_write_sram,
    input  logic          spk_write_sram_we,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          init_done
);

    spk_state_e    state;
    spk_state_e    next_state;
    logic [AW-1:0] clr_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          host_rd_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            host_rvalid <= 1'b0;
        end else begin
            state       <= next_state;
            host_rvalid <= host_rd_accept;
            // Counter wraps back to 0 after the last word, ready for the next sweep.
            if (state == CLEAR) begin
                clr_addr <= clr_addr + AW'(1);
            end
        end
    end

    always_comb begin
        next_state     = state;
        mem_we         = 1'b0;
        mem_waddr      = spk_write_sram_addr;
        mem_wdata      = spk_write_sram;
        host_ready     = 1'b0;
        host_rd_accept = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
                if (clr_addr == AW'(DEPTH - 1)) begin
                    next_state = SERVE;
                end
            end
            SERVE: begin
                host_ready     = !spk_write_sram_we;
                host_rd_accept = host_valid && !spk_write_sram_we && !host_wr;
                if (spk_write_sram_we) begin
                    mem_we = 1'b1;
                end else if (host_valid && host_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = host_addr;
                    mem_wdata = host_wdata;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    assign init_done = (state == SERVE);

    // Port A is the free-running accelerator read; port B only moves on an accepted host read.
    spk_sram_array #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .rd_en_a (state == SERVE),
        .raddr_a (spk_read_sram_addr),
        .rdata_a (spk_read_sram),
        .rd_en_b (host_rd_accept),
        .raddr_b (host_addr),
        .rdata_b (host_rdata)
    );

endmodule

// File: tb/tb_spk_sram_responder.sv
// Randomised bench for spk_sram_responder against a word-array reference model.
module tb_spk_sram_responder;
    import snn_mem_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] spk_read_sram_addr = '0;
    logic [DW-1:0] spk_read_sram;
    logic [AW-1:0] spk_write_sram_addr = '0;
    logic [DW-1:0] spk_write_sram = '0;
    logic          spk_write_sram_we = 1'b0;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic          host_wr = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          init_done;

    int checkCount = 0;
    int errorCount = 0;

    logic [DW-1:0] modelMem [DEPTH];
    bit            modelServe;
    int            sweepCount;
    logic [DW-1:0] expSpkRead;
    logic [DW-1:0] expHostRdata;
    bit            expRvalid;

    always #5 clk = ~clk;

    spk_sram_responder #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .spk_read_sram_addr  (spk_read_sram_addr),
        .spk_read_sram       (spk_read_sram),
        .spk_write_sram_addr (spk_write_sram_addr),
        .spk_write_sram      (spk_write_sram),
        .spk_write_sram_we   (spk_write_sram_we),
        .host_valid          (host_valid),
        .host_ready          (host_ready),
        .host_wr             (host_wr),
        .host_addr           (host_addr),
        .host_wdata          (host_wdata),
        .host_rdata          (host_rdata),
        .host_rvalid         (host_rvalid),
        .init_done           (init_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [AW-1:0] randAddr();
        // Half the traffic is squeezed into a few words so read/write collisions are common.
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic modelReset();
        modelServe   = 1'b0;
        sweepCount   = 0;
        expSpkRead   = '0;
        expHostRdata = '0;
        expRvalid    = 1'b0;
    endtask

    task automatic applyStimulus(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [AW-1:0] ra, input bit hv, input bit hw,
                                 input logic [AW-1:0] ha, input logic [DW-1:0] hwd);
        spk_write_sram_we   = we;
        spk_write_sram_addr = wa;
        spk_write_sram      = wd;
        spk_read_sram_addr  = ra;
        host_valid          = hv;
        host_wr             = hw;
        host_addr           = ha;
        host_wdata          = hwd;
        #1;
        checkOutput("host_ready", {31'd0, host_ready}, {31'd0, modelServe && !we});
        checkOutput("init_done", {31'd0, init_done}, {31'd0, modelServe});
        @(posedge clk);
        if (!modelServe) begin
            modelMem[sweepCount] = '0;
            sweepCount++;
            if (sweepCount == DEPTH) modelServe = 1'b1;
            expRvalid = 1'b0;
        end else begin
            if (we) modelMem[wa] = wd;
            else if (hv && hw) modelMem[ha] = hwd;
            expSpkRead = modelMem[ra];
            expRvalid  = hv && !we && !hw;
            if (expRvalid) expHostRdata = modelMem[ha];
        end
        #1;
        checkOutput("spk_read_sram", {16'd0, spk_read_sram}, {16'd0, expSpkRead});
        checkOutput("host_rvalid", {31'd0, host_rvalid}, {31'd0, expRvalid});
        checkOutput("host_rdata", {16'd0, host_rdata}, {16'd0, expHostRdata});
    endtask

    task automatic randomCycle(input int weakPct);
        applyStimulus(($urandom_range(0, 99) < weakPct), randAddr(), DW'($urandom), randAddr(),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, randAddr(), DW'($urandom));
    endtask

    task automatic pulseReset();
        spk_write_sram_we = 1'b0;
        host_valid        = 1'b1;
        host_wr           = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_spk_read_sram", {16'd0, spk_read_sram}, 32'd0);
        checkOutput("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
        checkOutput("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
        checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
        checkOutput("rst_host_ready", {31'd0, host_ready}, 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idleCycle(input logic [AW-1:0] ra);
        applyStimulus(1'b0, '0, '0, ra, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        modelReset();
        pulseReset();

        // Sweep with junk traffic on every input; none of it may land.
        for (int i = 0; i < DEPTH; i++) randomCycle(50);
        checkOutput("init_done_after_sweep", {31'd0, init_done}, 32'd1);

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(0), '0);
        checkOutput("host_rd_0", {16'd0, host_rdata}, 32'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(255), '0);
        checkOutput("host_rd_255", {16'd0, host_rdata}, 32'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(511), '0);
        checkOutput("host_rd_511", {16'd0, host_rdata}, 32'd0);

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, AW'(9'h010), 16'hA5A5);
        idleCycle(AW'(9'h010));
        checkOutput("acc_rd_after_host_wr", {16'd0, spk_read_sram}, 32'h0000A5A5);

        applyStimulus(1'b1, AW'(9'h020), 16'h1234, AW'(9'h020), 1'b0, 1'b0, '0, '0);
        checkOutput("acc_bypass", {16'd0, spk_read_sram}, 32'h00001234);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, AW'(9'h030 + i), DW'(i + 7), '0, 1'b1, 1'b1, AW'(9'h040), 16'hBEEF);
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, AW'(9'h040), 16'hBEEF);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(9'h040), '0);
        checkOutput("host_wr_after_stall", {16'd0, host_rdata}, 32'h0000BEEF);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(i), DW'(i + 1), '0, 1'b0, 1'b0, '0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
            checkOutput("b2b_rvalid", {31'd0, host_rvalid}, 32'd1);
            checkOutput("b2b_rdata", {16'd0, host_rdata}, 32'(i + 1));
        end
        idleCycle('0);
        checkOutput("rdata_hold", {16'd0, host_rdata}, 32'd4);

        for (int i = 0; i < 3000; i++) randomCycle(30);

        // Reset mid-SERVE, then again 100 words into the new sweep.
        pulseReset();
        for (int i = 0; i < 100; i++) randomCycle(50);
        pulseReset();
        for (int i = 0; i < DEPTH; i++) randomCycle(50);
        checkOutput("init_done_after_restart", {31'd0, init_done}, 32'd1);

        for (int i = 0; i < 500; i++) randomCycle(30);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/spk_sram_responder.md
SPK_SRAM_RESPONDER -- requirements
Module: spk_sram_responder

Interface
REQ-001 SHALL take parameter AW, default 9, as the address width.
REQ-002 SHALL take parameter DW, default 16, as the data width (one 16-neuron spike word).
REQ-003 SHALL take parameter DEPTH, default 512 (2**AW), as the number of words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port spk_read_sram_addr, input, AW bits: accelerator read address.
REQ-007 SHALL have port spk_read_sram, output, DW bits: accelerator read data.
REQ-008 SHALL have port spk_write_sram_addr, input, AW bits: accelerator write address.
REQ-009 SHALL have port spk_write_sram, input, DW bits: accelerator write data.
REQ-010 SHALL have port spk_write_sram_we, input, 1 bit: accelerator write enable.
REQ-011 SHALL have port host_valid, input, 1 bit: host request valid.
REQ-012 SHALL have port host_ready, output, 1 bit: host request accepted this cycle.
REQ-013 SHALL have port host_wr, input, 1 bit: 1 = host write, 0 = host read.
REQ-014 SHALL have port host_addr, input, AW bits: host address.
REQ-015 SHALL have port host_wdata, input, DW bits: host write data.
REQ-016 SHALL have port host_rdata, output, DW bits: host read data.
REQ-017 SHALL have port host_rvalid, output, 1 bit: one-cycle pulse marking host_rdata valid.
REQ-018 SHALL have port init_done, output, 1 bit: high once the clear sweep has finished.

Function
REQ-019 SHALL implement a two-state FSM, CLEAR and SERVE; it enters CLEAR on reset.
REQ-020 In CLEAR, SHALL write 0 to one word per cycle at an internal counter clr_addr running 0..DEPTH-1, then enter SERVE on the cycle after clr_addr = DEPTH-1 is written.
REQ-021 In CLEAR, SHALL ignore spk_write_sram_we, hold host_ready = 0, and drive spk_read_sram = 0.
REQ-022 In SERVE, SHALL register spk_read_sram_addr every cycle and present mem[addr] on spk_read_sram exactly 1 cycle later; no enable, continuous.
REQ-023 In SERVE, when spk_write_sram_we = 1, SHALL write spk_write_sram to mem[spk_write_sram_addr] at the clock edge.
REQ-024 On a same-cycle read and write to the same address, SHALL return the newly written data on the next cycle (write-first bypass); this applies to both the accelerator and host read paths.
REQ-025 SHALL drive host_ready = (state == SERVE) && !spk_write_sram_we; accelerator writes always take priority.
REQ-026 A host transfer SHALL occur only when host_valid && host_ready; the host holds host_wr, host_addr and host_wdata stable until accepted.
REQ-027 An accepted host write SHALL update mem[host_addr] at that edge.
REQ-028 An accepted host read SHALL set host_rvalid = 1 for exactly the next cycle, with host_rdata = mem[host_addr].
REQ-029 host_rdata SHALL hold its last value when host_rvalid = 0.
REQ-030 Back-to-back host reads SHALL sustain one transfer per cycle, with host_rvalid staying high on consecutive cycles.
REQ-031 Addresses SHALL be fully decoded; with DEPTH = 2**AW there is no out-of-range case and no wrap-around handling.

Reset
REQ-032 On reset low, SHALL asynchronously set: state = CLEAR, clr_addr = 0, spk_read_sram = 0, host_rdata = 0, host_rvalid = 0, init_done = 0, host_ready = 0.
REQ-033 Reset asserted mid-sweep or mid-SERVE SHALL abort any transfer in progress and restart the sweep from address 0 after release.
REQ-034 Memory contents SHALL NOT be reset asynchronously; they are cleared only by the sweep.

Structure
REQ-035 Package snn_mem_pkg SHALL hold SPK_AW, SPK_DW and SPK_DEPTH and the FSM state encoding (CLEAR = 0, SERVE = 1).
REQ-036 Storage SHALL be a sub-module spk_sram_array (2 read ports, 1 write port, registered reads, write-first bypass).
REQ-037 The FSM, arbitration and host handshake SHALL reside in the top module.

Verification
REQ-038 Reset release -> init_done = 0 for 512 cycles, rises on cycle 513; host reads of addresses 0, 255 and 511 return 0x0000.
REQ-039 Host write 0xA5A5 @ 0x010, then accelerator reads 0x010 -> spk_read_sram = 0xA5A5 one cycle after the address is applied.
REQ-040 Same cycle: accelerator write 0x1234 @ 0x020 with spk_read_sram_addr = 0x020 -> next cycle spk_read_sram = 0x1234.
REQ-041 host_valid held high while spk_write_sram_we = 1 for 3 cycles -> host_ready = 0 for those 3 cycles; the host write lands on the 4th cycle.
REQ-042 Reset pulsed at sweep count 100 -> the sweep restarts at 0 and init_done rises 512 cycles after release.
REQ-043 Four back-to-back host reads of 0x000..0x003 (preloaded 1..4) -> host_rvalid high for 4 consecutive cycles with host_rdata = 1, 2, 3, 4.
